// File: rtl/vga_pkg.sv
// Purpose : shared screen geometry, colour constants and the circle engine state enum.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_OCT  = 2'd2,
    S_DONE = 2'd3
  } circle_state_t;

endpackage

// File: rtl/circle_arc.sv
// Purpose : midpoint circle engine, one clipped candidate pixel per clock, windowed.
// Latency : start sampled -> first pixel registered 2 edges later; done one edge after last pixel.
// Backpressure: none; start is a level handshake, done held until start falls.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start / done                       level request / completion handshake
//   centre_x, centre_y, radius, colour circle parameters (latched at INIT)
//   win_xmin..win_ymax                 inclusive clip window (min > max clips everything)
//   vga_x, vga_y, vga_colour, vga_plot registered pixel write to the VGA adapter
module circle_arc
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       done,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] radius,
  input  logic [2:0] colour,
  input  logic [7:0] win_xmin,
  input  logic [7:0] win_xmax,
  input  logic [6:0] win_ymin,
  input  logic [6:0] win_ymax,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam logic signed [9:0] X_LAST = 10'(SCREEN_W - 1);
  localparam logic signed [9:0] Y_LAST = 10'(SCREEN_H - 1);

  circle_state_t state_q, state_d;

  // Latched request parameters
  logic [7:0] cx_q, xmin_q, xmax_q;
  logic [6:0] cy_q, ymin_q, ymax_q;
  logic [2:0] col_q;

  // Stepping variables
  logic [8:0]         ox_q, oy_q;
  logic signed [10:0] crit_q;
  logic [2:0]         k_q;

  // Candidate generation
  logic signed [9:0] cxs, cys, oxs, oys;
  logic signed [9:0] cand_x, cand_y;
  logic              in_screen, in_window;

  // Next-iteration values (computed every cycle, committed on k == 7)
  logic signed [10:0] oy_n, ox_n, crit_n;
  logic               last_iter;

  // Output-stage next values
  logic       plot_d, done_d;
  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [2:0] col_d;

  always_comb begin
    cxs    = signed'({2'b00, cx_q});
    cys    = signed'({3'b000, cy_q});
    oxs    = signed'({1'b0, ox_q});
    oys    = signed'({1'b0, oy_q});
    cand_x = cxs;
    cand_y = cys;
    case (k_q)
      3'd0: begin cand_x = cxs + oxs; cand_y = cys + oys; end
      3'd1: begin cand_x = cxs + oys; cand_y = cys + oxs; end
      3'd2: begin cand_x = cxs - oxs; cand_y = cys + oys; end
      3'd3: begin cand_x = cxs - oys; cand_y = cys + oxs; end
      3'd4: begin cand_x = cxs - oxs; cand_y = cys - oys; end
      3'd5: begin cand_x = cxs - oys; cand_y = cys - oxs; end
      3'd6: begin cand_x = cxs + oxs; cand_y = cys - oys; end
      default: begin cand_x = cxs + oys; cand_y = cys - oxs; end
    endcase
  end

  // Clip on the signed candidate so off-screen negatives never alias onto the screen
  always_comb begin
    in_screen = (cand_x >= 10'sd0) && (cand_x <= X_LAST) &&
                (cand_y >= 10'sd0) && (cand_y <= Y_LAST);
    in_window = (cand_x >= signed'({2'b00, xmin_q})) && (cand_x <= signed'({2'b00, xmax_q})) &&
                (cand_y >= signed'({3'b000, ymin_q})) && (cand_y <= signed'({3'b000, ymax_q}));
  end

  // ox may step to -1 (radius 0), so the termination compare is done signed and wide
  always_comb begin
    oy_n = signed'({2'b00, oy_q}) + 11'sd1;
    if (crit_q <= 11'sd0) begin
      ox_n   = signed'({2'b00, ox_q});
      crit_n = crit_q + (oy_n <<< 1) + 11'sd1;
    end else begin
      ox_n   = signed'({2'b00, ox_q}) - 11'sd1;
      crit_n = crit_q + ((oy_n - ox_n) <<< 1) + 11'sd1;
    end
    last_iter = (oy_n > ox_n);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: state_d = S_OCT;
      S_OCT:  if ((k_q == 3'd7) && last_iter) state_d = S_DONE;
      S_DONE: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic (registered below)
  always_comb begin
    plot_d = (state_q == S_OCT) && in_screen && in_window;
    x_d    = plot_d ? cand_x[7:0] : 8'd0;
    y_d    = plot_d ? cand_y[6:0] : 7'd0;
    col_d  = plot_d ? col_q : BLACK;
    done_d = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_plot   <= 1'b0;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= BLACK;
      done       <= 1'b0;
    end else begin
      vga_plot   <= plot_d;
      vga_x      <= x_d;
      vga_y      <= y_d;
      vga_colour <= col_d;
      done       <= done_d;
    end
  end

  // Datapath: latch on INIT, octant counter and stepping during OCT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q   <= 8'd0;
      cy_q   <= 7'd0;
      col_q  <= BLACK;
      xmin_q <= 8'd0;
      xmax_q <= 8'd0;
      ymin_q <= 7'd0;
      ymax_q <= 7'd0;
      ox_q   <= 9'd0;
      oy_q   <= 9'd0;
      crit_q <= 11'sd0;
      k_q    <= 3'd0;
    end else begin
      case (state_q)
        S_INIT: begin
          cx_q   <= centre_x;
          cy_q   <= centre_y;
          col_q  <= colour;
          xmin_q <= win_xmin;
          xmax_q <= win_xmax;
          ymin_q <= win_ymin;
          ymax_q <= win_ymax;
          ox_q   <= {1'b0, radius};
          oy_q   <= 9'd0;
          crit_q <= 11'sd1 - signed'({3'b000, radius});
          k_q    <= 3'd0;
        end
        S_OCT: begin
          k_q <= k_q + 3'd1;
          if (k_q == 3'd7) begin
            oy_q   <= oy_n[8:0];
            ox_q   <= ox_n[8:0];
            crit_q <= crit_n;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_arc.sv
module tb_circle_arc;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       done;
  logic [7:0] centre_x = '0, radius = '0, win_xmin = '0, win_xmax = '0;
  logic [6:0] centre_y = '0, win_ymin = '0, win_ymax = '0;
  logic [2:0] colour = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  circle_arc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius), .colour(colour),
    .win_xmin(win_xmin), .win_xmax(win_xmax), .win_ymin(win_ymin), .win_ymax(win_ymax),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       done;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t exp_q[$];   // per-cycle expected outputs, consumed by the compare process
  exp_t cand_q[$];  // candidate stream produced by the model

  int n_cmp = 0;
  int n_bad = 0;
  bit seen[int];
  int plot_cnt = 0;
  int max_y = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: walk the circle with plain integers, eight reflections per iteration
  function automatic int model(input int cx, cy, r, col, xmin, xmax, ymin, ymax);
    int ox, oy, crit, it, x, y;
    int px[8];
    int py[8];
    bit vis;
    exp_t e;
    ox = r; oy = 0; crit = 1 - r; it = 0;
    cand_q.delete();
    while (oy <= ox) begin
      px = '{ox, oy, -ox, -oy, -ox, -oy, ox, oy};
      py = '{oy, ox, oy, ox, -oy, -ox, -oy, -ox};
      for (int k = 0; k < 8; k++) begin
        x = cx + px[k];
        y = cy + py[k];
        vis = (x >= 0) && (x < SCREEN_W) && (y >= 0) && (y < SCREEN_H) &&
              (x >= xmin) && (x <= xmax) && (y >= ymin) && (y <= ymax);
        e.done = 1'b0;
        e.plot = vis;
        e.x = vis ? 8'(x) : 8'd0;
        e.y = vis ? 7'(y) : 7'd0;
        e.c = vis ? 3'(col) : 3'd0;
        cand_q.push_back(e);
      end
      it++;
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end
    return it;
  endfunction

  function automatic bit model_has(input int x, input int y);
    foreach (cand_q[i])
      if (cand_q[i].plot && cand_q[i].x == 8'(x) && cand_q[i].y == 7'(y)) return 1'b1;
    return 1'b0;
  endfunction

  // Compare process: one check per cycle while an expectation is pending
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cycle{done,plot,x,y,colour}", {12'd0, done, vga_plot, vga_x, vga_y, vga_colour},
          {12'd0, e.done, e.plot, e.x, e.y, e.c});
      if (vga_plot) begin
        seen[int'({vga_x, vga_y})] = 1'b1;
        plot_cnt++;
        if (int'(vga_y) > max_y) max_y = int'(vga_y);
      end
    end
  end

  task automatic wait_empty(input string name);
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: %0d expectations still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input int cx, cy, r, col, xmin, xmax, ymin, ymax, hold, input bit drop_early);
    int it;
    exp_t z;
    it = model(cx, cy, r, col, xmin, xmax, ymin, ymax);
    @(negedge clk);
    rst_n    = 1'b1;
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    radius   = 8'(r);
    colour   = 3'(col);
    win_xmin = 8'(xmin);
    win_xmax = 8'(xmax);
    win_ymin = 7'(ymin);
    win_ymax = 7'(ymax);
    start    = 1'b1;
    z = '{1'b0, 1'b0, 8'd0, 7'd0, 3'd0};
    exp_q.push_back(z);  // edge sampling start
    exp_q.push_back(z);  // INIT edge
    foreach (cand_q[i]) exp_q.push_back(cand_q[i]);
    z.done = 1'b1;
    if (drop_early) begin
      exp_q.push_back(z);
      z.done = 1'b0;
      exp_q.push_back(z);
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_empty("drain");
    end else begin
      repeat (hold + 1) exp_q.push_back(z);
      wait_empty("hold");
      start = 1'b0;
      exp_q.push_back(z);
      z.done = 1'b0;
      exp_q.push_back(z);
      wait_empty("release");
    end
  endtask

  initial begin
    int it;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {27'd0, done, vga_plot, vga_colour}, 32'd0);
    chk("reset_xy", {17'd0, vga_x, vga_y}, 32'd0);

    // Radius 0: eight pulses on the centre pixel
    it = model(80, 60, 0, GREEN, 0, 159, 0, 119);
    chk("model_r0_iters", it, 1);
    seen.delete(); plot_cnt = 0;
    run(80, 60, 0, GREEN, 0, 159, 0, 119, 0, 1'b0);
    chk("r0_plot_count", plot_cnt, 8);
    chk("r0_distinct", seen.num(), 1);
    chk("r0_centre", seen.exists(int'({8'd80, 7'd60})), 1);

    // Radius 3: hand-computed pixels pin both the model and the DUT
    it = model(80, 60, 3, GREEN, 0, 159, 0, 119);
    chk("model_r3_iters", it, 3);
    chk("model_r3_pix", {26'd0, model_has(83, 60), model_has(80, 63), model_has(77, 60),
                         model_has(80, 57), model_has(83, 61), model_has(82, 62)}, 32'h3f);
    seen.delete(); plot_cnt = 0;
    run(80, 60, 3, GREEN, 0, 159, 0, 119, 2, 1'b0);
    chk("r3_plot_count", plot_cnt, 24);
    chk("r3_pix_83_60", seen.exists(int'({8'd83, 7'd60})), 1);
    chk("r3_pix_80_63", seen.exists(int'({8'd80, 7'd63})), 1);
    chk("r3_pix_77_60", seen.exists(int'({8'd77, 7'd60})), 1);
    chk("r3_pix_80_57", seen.exists(int'({8'd80, 7'd57})), 1);
    chk("r3_pix_83_61", seen.exists(int'({8'd83, 7'd61})), 1);
    chk("r3_pix_82_62", seen.exists(int'({8'd82, 7'd62})), 1);

    // Corner centre: negative candidates clipped, cycle count unchanged
    run(0, 0, 10, 3'b101, 0, 159, 0, 119, 0, 1'b0);

    // Upper-half window
    max_y = 0; plot_cnt = 0;
    run(80, 60, 20, GREEN, 0, 159, 0, 60, 0, 1'b0);
    chk("win_max_y_le_60", (max_y <= 60), 1);
    chk("win_some_plots", (plot_cnt > 0), 1);

    // Long hold on done, then immediate restart; then start dropped mid-operation
    run(40, 30, 5, 3'b111, 0, 159, 0, 119, 50, 1'b0);
    run(100, 90, 7, 3'b011, 0, 159, 0, 119, 0, 1'b1);

    // Empty window: everything clipped
    run(80, 60, 12, GREEN, 100, 20, 0, 119, 1, 1'b0);

    // Asynchronous reset mid-iteration, restart with start held high
    @(negedge clk);
    centre_x = 8'd80; centre_y = 7'd60; radius = 8'd20; colour = GREEN;
    win_xmin = 8'd0; win_xmax = 8'd159; win_ymin = 7'd0; win_ymax = 7'd119;
    start = 1'b1;
    repeat (13) @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_reset_outputs", {27'd0, done, vga_plot, vga_colour}, 32'd0);
    chk("async_reset_xy", {17'd0, vga_x, vga_y}, 32'd0);
    repeat (2) @(negedge clk);
    run(80, 60, 20, GREEN, 0, 159, 0, 119, 0, 1'b0);

    // Randomised circles and windows
    for (int n = 0; n < 16; n++) begin
      run($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 100),
          $urandom_range(0, 7), $urandom_range(0, 170), $urandom_range(0, 170),
          $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 3),
          1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
